pcs_tx_sequencer: RTL and testbench
===================================

# pcs_tx_sequencer

Bring-up and run-time controller for the 64b/66b PCS transmit path. Debounces the PMA `READY`, then sequences the per-lane encoder and scrambler enables and loads the scrambler seed. It forces idle control blocks until the link is up, then hands the datapath to the upstream MAC through a valid/accept handshake. It sits beside the encoder/scrambler lanes, drives their enables and the idle-insert mux, and watches encoder error flags to declare a fault.

## Interface
- `LANES`, 2, number of encoder/scrambler lanes
- `READY_DEBOUNCE`, 16, consecutive `READY`-high cycles required (≥2)
- `ENC_LATENCY`, 2, encoder warm-up cycles before seeding the scrambler (≥1)
- `IDLE_BLOCKS`, 8, idle blocks sent after seeding, before `LINK_UP` (≥1)
- `ERR_WINDOW`, 64, error-monitor window length in cycles (power of 2)
- `ERR_THRESH`, 4, errored lane-cycles per window that trigger a fault
- `TX_CLK`  in  1  sole clock, all logic on rising edge
- `RST_N`  in  1  asynchronous, active-low reset
- `READY`  in  1  PMA ready, synchronous to `TX_CLK`
- `MAC_VALID`  in  1  upstream has a 64b-per-lane block on `TX_D`/`TX_C`
- `ENC_ERR`  in  LANES  per-lane encoder error flag, one cycle per error
- `MAC_ACCEPT`  out  1  block accepted this cycle
- `ENABLE_ENCODER`  out  1  to all encoder lanes
- `ENABLE_SCRAMBLER`  out  1  to all scrambler lanes
- `SCR_SEED_LOAD`  out  1  one-cycle scrambler seed load
- `IDLE_INSERT`  out  1  selects the idle block instead of MAC data at the encoder input
- `LINK_UP`  out  1  datapath owned by the MAC
- `FAULT`  out  1  error threshold exceeded
- `STATE`  out  3  current FSM state encoding
- `ERR_COUNT`  out  8  saturating total of errored lane-cycles since reset

## Operation
- FSM (encoding): DOWN=0, DEBOUNCE=1, ENC_WARM=2, SEED=3, IDLE=4, DATA=5, FAULT=6.
- DOWN: all enables 0. `READY`=1 → DEBOUNCE, counter=0.
- DEBOUNCE: `READY`=1 and counter==`READY_DEBOUNCE`-1 → ENC_WARM; otherwise counter++.
- ENC_WARM: `ENABLE_ENCODER`=1, `IDLE_INSERT`=1 for `ENC_LATENCY` cycles → SEED.
- SEED: exactly one cycle. `SCR_SEED_LOAD`=1, `ENABLE_SCRAMBLER`=1, `IDLE_INSERT`=1 → IDLE.
- IDLE: `ENABLE_SCRAMBLER`=1, `IDLE_INSERT`=1 for `IDLE_BLOCKS` cycles → DATA.
- DATA: `LINK_UP`=1, `MAC_ACCEPT`=1, `IDLE_INSERT`=~`MAC_VALID`. A transfer occurs when `MAC_VALID`&`MAC_ACCEPT`. Stays in DATA until a fault or `READY` loss.
- FAULT: all enables 0, `FAULT`=1, `MAC_ACCEPT`=0. Leaves only via `READY`=0 → DOWN.
- Priority: reset > `READY`=0 (any state → DOWN next edge) > fault > normal transition.
- Error monitor: active in ENC_WARM..DATA only. Each cycle adds popcount(`ENC_ERR`) to a window count. A free-running window counter wraps every `ERR_WINDOW` cycles.
  - On wrap, the window count restarts at the current cycle's popcount.
  - If the window count including the current cycle reaches ≥`ERR_THRESH`, the FSM goes to FAULT on that edge.
  - Window counter and window count clear on entry to DOWN.
- `ERR_COUNT`: adds popcount(`ENC_ERR`) in every state and saturates at 255. Only reset clears it.

## Timing
- All outputs are registered Moore outputs. Reset value of every output is 0, `STATE`=0.
- Take the first edge sampling `READY`=1 as edge 0. Then:
  - `ENABLE_ENCODER` rises after edge `READY_DEBOUNCE`.
  - `SCR_SEED_LOAD` is high during the cycle after edge `READY_DEBOUNCE`+`ENC_LATENCY`.
  - `LINK_UP` rises after edge `READY_DEBOUNCE`+`ENC_LATENCY`+1+`IDLE_BLOCKS`, which is 27 with the defaults.
- `READY` low for one cycle inside DEBOUNCE restarts the debounce from DOWN.
- `MAC_ACCEPT` falls on the same edge that `STATE` leaves DATA. Zero-latency handshake, no buffering inside the block.
- `RST_N` asserted mid-operation clears all outputs immediately, asynchronously. Deassertion is synchronised externally.

## Structure
- `pcs_pkg` holds:
  - the `pcs_tx_state_t` enum
  - `PCS_IDLE_DATA` = 64'h0707070707070707 and `PCS_IDLE_CTRL` = 8'hFF
  - the shared `LANES`/`DATA_WIDTH`/`HEADER_WIDTH` defaults
- Sub-module `pcs_err_monitor`: window counter, popcount, threshold compare and saturating `ERR_COUNT`. The FSM stays in `pcs_tx_sequencer`.

## Test plan
- Bring-up: `READY` held high from edge 0 with defaults, no errors.
  - `ENABLE_ENCODER` rises after edge 16.
  - `SCR_SEED_LOAD` pulses exactly one cycle after edge 18.
  - `LINK_UP` rises after edge 27, with `IDLE_INSERT`=1 throughout 16–27.
- Debounce glitch: `READY` high 10 cycles, low 1, then high → `STATE` returns to 0, and `ENABLE_ENCODER` rises 16 edges after the re-rise.
- Handshake in DATA: `MAC_VALID` toggles 1,0,1 → `MAC_ACCEPT`=1 constantly and `IDLE_INSERT`=0,1,0.
- Fault: in DATA, `ENC_ERR`=2'b11 on two cycles within one window → `STATE`=6, `FAULT`=1, enables 0, `ERR_COUNT`=4. Then `READY`=0 → `STATE`=0.
- Window wrap: 3 errors late in one window plus 3 early in the next → no fault, `ERR_COUNT`=6.
- Async reset mid-DATA: `RST_N` low between edges → all outputs 0 before the next edge, `ERR_COUNT`=0.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared types and constants for the 64b/66b PCS transmit control slice.
package pcs_pkg;

  localparam int PCS_LANES        = 2;
  localparam int PCS_DATA_WIDTH   = 64;
  localparam int PCS_HEADER_WIDTH = 2;

  localparam logic [PCS_DATA_WIDTH-1:0] PCS_IDLE_DATA = 64'h0707070707070707;
  localparam logic [7:0]                PCS_IDLE_CTRL = 8'hFF;

  typedef enum logic [2:0] {
    ST_DOWN     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_ENC_WARM = 3'd2,
    ST_SEED     = 3'd3,
    ST_IDLE     = 3'd4,
    ST_DATA     = 3'd5,
    ST_FAULT    = 3'd6
  } pcs_tx_state_t;

endpackage

// File: rtl/pcs_tx_sequencer_if.sv
// MAC handshake plus per-lane encoder/scrambler control bundle.
interface pcs_tx_sequencer_if #(
  parameter int LANES = pcs_pkg::PCS_LANES
);
  logic             MAC_VALID;
  logic             MAC_ACCEPT;
  logic [LANES-1:0] ENC_ERR;
  logic             ENABLE_ENCODER;
  logic             ENABLE_SCRAMBLER;
  logic             SCR_SEED_LOAD;
  logic             IDLE_INSERT;

  // master: the MAC and lane side; slave: the sequencer.
  modport master (
    output MAC_VALID, ENC_ERR,
    input  MAC_ACCEPT, ENABLE_ENCODER, ENABLE_SCRAMBLER, SCR_SEED_LOAD, IDLE_INSERT
  );

  modport slave (
    input  MAC_VALID, ENC_ERR,
    output MAC_ACCEPT, ENABLE_ENCODER, ENABLE_SCRAMBLER, SCR_SEED_LOAD, IDLE_INSERT
  );
endinterface

// File: rtl/pcs_err_monitor.sv
// Encoder error monitor: windowed threshold detect plus saturating lifetime count.
module pcs_err_monitor import pcs_pkg::*; #(
  parameter int LANES      = PCS_LANES,
  parameter int ERR_WINDOW = 64,
  parameter int ERR_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active,
  input  logic             clr,
  input  logic [LANES-1:0] enc_err,
  output logic             fault_hit,
  output logic [7:0]       err_count
);

  localparam int WIN_W = $clog2(ERR_WINDOW);
  localparam int POP_W = $clog2(LANES + 1);
  localparam int CNT_W = $clog2(LANES * ERR_WINDOW + 1);

  logic [WIN_W-1:0] win_ctr;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] win_base;
  logic [CNT_W-1:0] win_sum;
  logic [POP_W-1:0] pop;

  function automatic logic [POP_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [POP_W-1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + 9'(b);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Window count includes the current cycle; a window-start cycle drops history.
  always_comb begin
    pop       = popcount(enc_err);
    win_base  = (win_ctr == '0) ? '0 : win_cnt;
    win_sum   = win_base + CNT_W'(pop);
    fault_hit = active && (32'(win_sum) >= 32'(ERR_THRESH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_ctr   <= '0;
      win_cnt   <= '0;
      err_count <= '0;
    end else begin
      err_count <= sat_add8(err_count, pop);
      if (clr) begin
        win_ctr <= '0;
        win_cnt <= '0;
      end else begin
        win_ctr <= win_ctr + WIN_W'(1);
        win_cnt <= active ? win_sum : '0;
      end
    end
  end

endmodule

// File: rtl/pcs_tx_sequencer.sv
// PCS TX bring-up/run-time sequencer: READY debounce, encoder/scrambler sequencing,
// idle insertion until link-up, MAC handshake and encoder-error fault detection.
module pcs_tx_sequencer import pcs_pkg::*; #(
  parameter int LANES          = PCS_LANES,
  parameter int READY_DEBOUNCE = 16,
  parameter int ENC_LATENCY    = 2,
  parameter int IDLE_BLOCKS    = 8,
  parameter int ERR_WINDOW     = 64,
  parameter int ERR_THRESH     = 4
) (
  input  logic                TX_CLK,
  input  logic                RST_N,
  input  logic                READY,
  pcs_tx_sequencer_if.slave   bus,
  output logic                LINK_UP,
  output logic                FAULT,
  output logic [2:0]          STATE,
  output logic [7:0]          ERR_COUNT
);

  localparam int CNT_MAX0 = (READY_DEBOUNCE > ENC_LATENCY) ? READY_DEBOUNCE : ENC_LATENCY;
  localparam int CNT_MAX  = (CNT_MAX0 > IDLE_BLOCKS) ? CNT_MAX0 : IDLE_BLOCKS;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(READY_DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(ENC_LATENCY - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_BLOCKS - 1);

  pcs_tx_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic enc_en_q, scr_en_q, seed_q, idle_q, link_q, fault_q;
  logic mon_active, mon_clr, fault_hit;

  assign mon_active = (state_q == ST_ENC_WARM) || (state_q == ST_SEED) ||
                      (state_q == ST_IDLE)     || (state_q == ST_DATA);
  assign mon_clr    = (state_q == ST_DOWN);

  pcs_err_monitor #(
    .LANES      (LANES),
    .ERR_WINDOW (ERR_WINDOW),
    .ERR_THRESH (ERR_THRESH)
  ) u_err_monitor (
    .clk       (TX_CLK),
    .rst_n     (RST_N),
    .active    (mon_active),
    .clr       (mon_clr),
    .enc_err   (bus.ENC_ERR),
    .fault_hit (fault_hit),
    .err_count (ERR_COUNT)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      ST_DOWN: begin
        cnt_d = '0;
        if (READY) state_d = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (cnt_q == DEB_LAST) begin
          state_d = ST_ENC_WARM;
          cnt_d   = '0;
        end
      end
      ST_ENC_WARM: begin
        if (cnt_q == WARM_LAST) begin
          state_d = ST_SEED;
          cnt_d   = '0;
        end
      end
      ST_SEED: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      ST_IDLE: begin
        if (cnt_q == IDLE_LAST) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA:  cnt_d = '0;
      ST_FAULT: cnt_d = '0;
      default: begin
        state_d = ST_DOWN;
        cnt_d   = '0;
      end
    endcase
    // Loss of READY outranks a fault, which outranks the normal sequence.
    if (fault_hit) state_d = ST_FAULT;
    if (!READY) begin
      state_d = ST_DOWN;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge TX_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_DOWN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as STATE.
  always_ff @(posedge TX_CLK or negedge RST_N) begin
    if (!RST_N) begin
      enc_en_q <= 1'b0;
      scr_en_q <= 1'b0;
      seed_q   <= 1'b0;
      idle_q   <= 1'b0;
      link_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      enc_en_q <= (state_d == ST_ENC_WARM) || (state_d == ST_SEED) ||
                  (state_d == ST_IDLE)     || (state_d == ST_DATA);
      scr_en_q <= (state_d == ST_SEED) || (state_d == ST_IDLE) || (state_d == ST_DATA);
      seed_q   <= (state_d == ST_SEED);
      idle_q   <= (state_d == ST_ENC_WARM) || (state_d == ST_SEED) || (state_d == ST_IDLE);
      link_q   <= (state_d == ST_DATA);
      fault_q  <= (state_d == ST_FAULT);
    end
  end

  // In DATA the idle mux must follow MAC_VALID in the same cycle: no buffering here.
  assign bus.MAC_ACCEPT       = link_q;
  assign bus.ENABLE_ENCODER   = enc_en_q;
  assign bus.ENABLE_SCRAMBLER = scr_en_q;
  assign bus.SCR_SEED_LOAD    = seed_q;
  assign bus.IDLE_INSERT      = idle_q | (link_q & ~bus.MAC_VALID);
  assign LINK_UP              = link_q;
  assign FAULT                = fault_q;
  assign STATE                = state_q;

endmodule

// File: tb/tb_pcs_tx_sequencer.sv
// Directed scoreboard bench for pcs_tx_sequencer with default parameters.
module tb_pcs_tx_sequencer;

  localparam int D  = 16;
  localparam int L  = 2;
  localparam int I  = 8;
  localparam int UP = D + L + 1 + I;

  logic       TX_CLK = 1'b0;
  logic       RST_N;
  logic       READY;
  logic       LINK_UP;
  logic       FAULT;
  logic [2:0] STATE;
  logic [7:0] ERR_COUNT;

  always #5 TX_CLK = ~TX_CLK;

  pcs_tx_sequencer_if #(.LANES(2)) bus ();

  pcs_tx_sequencer #(
    .LANES(2), .READY_DEBOUNCE(D), .ENC_LATENCY(L), .IDLE_BLOCKS(I),
    .ERR_WINDOW(64), .ERR_THRESH(4)
  ) dut (
    .TX_CLK    (TX_CLK),
    .RST_N     (RST_N),
    .READY     (READY),
    .bus       (bus.slave),
    .LINK_UP   (LINK_UP),
    .FAULT     (FAULT),
    .STATE     (STATE),
    .ERR_COUNT (ERR_COUNT)
  );

  typedef struct {
    string       tag;
    logic [17:0] v;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   exp_err = 0;

  // Expected outputs from the state-by-state behaviour description.
  function automatic logic [17:0] model(input logic [2:0] st, input logic mv, input int errc);
    logic acc, enc, scr, seed, idl, lnk, flt;
    {acc, enc, scr, seed, idl, lnk, flt} = '0;
    case (st)
      3'd2: begin enc = 1; idl = 1; end
      3'd3: begin enc = 1; scr = 1; seed = 1; idl = 1; end
      3'd4: begin enc = 1; scr = 1; idl = 1; end
      3'd5: begin enc = 1; scr = 1; lnk = 1; acc = 1; idl = !mv; end
      3'd6: flt = 1;
      default: ;
    endcase
    return {acc, enc, scr, seed, idl, lnk, flt, st, errc[7:0]};
  endfunction

  function automatic logic [17:0] observed();
    return {bus.MAC_ACCEPT, bus.ENABLE_ENCODER, bus.ENABLE_SCRAMBLER, bus.SCR_SEED_LOAD,
            bus.IDLE_INSERT, LINK_UP, FAULT, STATE, ERR_COUNT};
  endfunction

  task automatic push(input string tag, input logic [2:0] st);
    exp_t e;
    e.tag = tag;
    e.v   = model(st, bus.MAC_VALID, exp_err);
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [17:0] o;
    e = sb.pop_front();
    o = observed();
    tests++;
    assert (o === e.v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", e.tag, o, e.v);
    end
  endtask

  task automatic step();
    @(posedge TX_CLK);
    #1;
    cyc++;
  endtask

  task automatic tick(input string tag, input logic [2:0] st);
    push(tag, st);
    step();
    check();
  endtask

  task automatic drive_err(input logic [1:0] v);
    bus.ENC_ERR = v;
    exp_err = exp_err + int'(v[0]) + int'(v[1]);
    if (exp_err > 255) exp_err = 255;
  endtask

  // Edge 0 is the first edge that samples READY=1.
  task automatic bring_up(input string tag);
    logic [2:0] st;
    READY = 1'b1;
    cyc   = -1;
    for (int k = 0; k <= UP; k++) begin
      if (k < D)          st = 3'd1;
      else if (k < D + L) st = 3'd2;
      else if (k == D + L) st = 3'd3;
      else if (k < UP)    st = 3'd4;
      else                st = 3'd5;
      tick($sformatf("%s_e%0d", tag, k), st);
    end
  endtask

  initial begin
    RST_N = 1'b0;
    READY = 1'b0;
    bus.MAC_VALID = 1'b0;
    bus.ENC_ERR   = 2'b00;
    repeat (2) @(posedge TX_CLK);
    #1;
    push("reset", 3'd0);
    check();
    RST_N = 1'b1;
    tick("down_hold0", 3'd0);
    tick("down_hold1", 3'd0);

    // Debounce glitch: 10 good cycles, one drop, then a full bring-up.
    READY = 1'b1;
    for (int k = 0; k < 10; k++) tick($sformatf("glitch_deb%0d", k), 3'd1);
    READY = 1'b0;
    tick("glitch_drop", 3'd0);
    bring_up("rerise");

    // Handshake: accept stays high, idle insert follows ~MAC_VALID in-cycle.
    for (int k = 0; k < 3; k++) begin
      bus.MAC_VALID = (k != 1);
      #1;
      push($sformatf("hs%0d", k), 3'd5);
      check();
      step();
    end
    bus.MAC_VALID = 1'b0;

    // Window wrap: errors in cycles 61..63 and 64..66 straddle a window boundary.
    while (cyc < 61) tick("wrap_wait", 3'd5);
    for (int k = 0; k < 6; k++) begin
      drive_err(2'b01);
      tick($sformatf("wrap_err%0d", k), 3'd5);
    end
    drive_err(2'b00);
    tick("wrap_total6", 3'd5);

    // Asynchronous reset between edges while in DATA.
    bus.MAC_VALID = 1'b1;
    #2;
    RST_N   = 1'b0;
    exp_err = 0;
    #1;
    push("async_rst", 3'd0);
    check();
    @(posedge TX_CLK);
    #1;
    READY = 1'b0;
    bus.MAC_VALID = 1'b0;
    RST_N = 1'b1;
    tick("post_rst_down", 3'd0);

    // Fault: two double-lane errors within one window.
    bring_up("fault_bu");
    drive_err(2'b11);
    tick("flt_err1", 3'd5);
    drive_err(2'b00);
    tick("flt_gap", 3'd5);
    drive_err(2'b11);
    tick("flt_err2", 3'd6);
    drive_err(2'b00);
    tick("flt_hold", 3'd6);
    READY = 1'b0;
    tick("flt_ready_lost", 3'd0);

    // Lifetime error count saturates at 255.
    for (int k = 0; k < 130; k++) begin
      drive_err(2'b11);
      step();
    end
    drive_err(2'b00);
    tick("err_saturate", 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
